// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Op codes, FSM states and the fixed latency constant.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int MULDIV_W   = 32;
  localparam int MULDIV_LAT = MULDIV_W + 2;

  function automatic logic op_is_div(
    input logic [1:0] op
  );
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(
    input logic [1:0] op
  );
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate.
// o_out = i_en ? -i_in : i_in, over W bits.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_in,
  input  logic         i_en,
  output logic [W-1:0] o_out
);

  assign o_out = i_en ? (~i_in + W'(1)) : i_in;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MIPS HI/LO multiply/divide, one bit per cycle.
// Build option: MULTDIV_SIGNED_EN enables signed MULT/DIV.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             MoveEn,
  input  logic             MoveSel,
  input  logic [WIDTH-1:0] MoveData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_hi_w;
  logic [WIDTH-1:0]   r_lo_w;
  logic [WIDTH-1:0]   r_b_w;
  logic [WIDTH-1:0]   r_HI;
  logic [WIDTH-1:0]   r_LO;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic               w_b_zero;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

`ifdef MULTDIV_SIGNED_EN
  logic               r_signed;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  muldiv_negate #(.W(WIDTH)) u_neg_a (
    .i_in  (OperandA),
    .i_en  (r_signed & OperandA[WIDTH-1]),
    .o_out (w_a_abs)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_b (
    .i_in  (OperandB),
    .i_en  (r_signed & OperandB[WIDTH-1]),
    .o_out (w_b_abs)
  );

  muldiv_negate #(.W(2*WIDTH)) u_neg_prod (
    .i_in  ({r_hi_w, r_lo_w}),
    .i_en  (r_neg_lo),
    .o_out (w_prod)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_quo (
    .i_in  (r_lo_w),
    .i_en  (r_neg_lo),
    .o_out (w_quo)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_rem (
    .i_in  (r_hi_w),
    .i_en  (r_neg_hi),
    .o_out (w_rem)
  );

  assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];
`else
  logic w_unused_op0;

  assign w_unused_op0 = Op[0];
  assign w_a_abs      = OperandA;
  assign w_b_abs      = OperandB;
  assign w_res_hi     = r_hi_w;
  assign w_res_lo     = r_lo_w;
`endif

  assign w_b_zero = (OperandB == '0);

  // Multiply step: add multiplicand on LSB, shift {carry,hi,lo} right.
  assign w_mul_sum = {1'b0, r_hi_w}
                   + (r_lo_w[0] ? {1'b0, r_b_w} : '0);

  // Divide step: shift next dividend bit into remainder, trial subtract.
  assign w_div_sh   = {r_hi_w, r_lo_w[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b_w};
  assign w_div_ok   = ~w_div_diff[WIDTH];

  // Control FSM plus datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_hi_w   <= '0;
      r_lo_w   <= '0;
      r_b_w    <= '0;
      r_HI     <= '0;
      r_LO     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
      r_signed <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state  <= S_PREP;
            r_busy   <= 1'b1;
            r_is_div <= op_is_div(Op);
`ifdef MULTDIV_SIGNED_EN
            r_signed <= op_is_signed(Op);
`endif
          end else if (MoveEn) begin
            if (MoveSel) r_HI <= MoveData;
            else         r_LO <= MoveData;
          end
        end
        S_PREP: begin
          if (r_is_div && w_b_zero) begin
            r_state <= S_DONE;
            r_HI    <= OperandA;
            r_LO    <= '1;
            r_done  <= 1'b1;
            r_dbz   <= 1'b1;
          end else begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_hi_w  <= '0;
            r_lo_w  <= r_is_div ? w_a_abs : w_b_abs;
            r_b_w   <= r_is_div ? w_b_abs : w_a_abs;
`ifdef MULTDIV_SIGNED_EN
            r_neg_lo <= r_signed
                      & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            r_neg_hi <= r_signed & OperandA[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_hi_w <= w_div_ok ? w_div_diff[WIDTH-1:0]
                               : w_div_sh[WIDTH-1:0];
            r_lo_w <= {r_lo_w[WIDTH-2:0], w_div_ok};
          end else begin
            r_hi_w <= w_mul_sum[WIDTH:1];
            r_lo_w <= {w_mul_sum[0], r_lo_w[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_HI    <= w_res_hi;
          r_LO    <= w_res_lo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz;
  assign HI        = r_HI;
  assign LO        = r_LO;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv.
// Reference model plus per-cycle compare and literal checks.
module tb_hilo_muldiv;

  localparam int LAT = 34;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        MoveEn;
  logic        MoveSel;
  logic [31:0] MoveData;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk = 0;
  int n_err = 0;

  hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .MoveEn    (MoveEn),
    .MoveSel   (MoveSel),
    .MoveData  (MoveData),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Result from plain arithmetic: {dbz, hi, lo}.
  function automatic logic [64:0] ref_op(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic sgn;
    logic signed [63:0] sa, sb, q, r, p;
    sgn = op[0];
`ifndef MULTDIV_SIGNED_EN
    sgn = 1'b0;
`endif
    sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    if (!op[1]) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Transaction-level model of what the outputs must show.
  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_res;
  int          m_rem;

  always @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_dbz   <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_rem   <= 0;
      m_res   <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (!m_busy) begin
        if (Start) begin
          m_res  <= ref_op(Op, OperandA, OperandB);
          m_busy <= 1'b1;
          m_rem  <= (Op[1] && OperandB == 32'd0) ? 1 : LAT;
        end else if (MoveEn) begin
          if (MoveSel) m_hi <= MoveData;
          else         m_lo <= MoveData;
        end
      end else if (m_rem == 0) begin
        m_busy <= 1'b0;
      end else begin
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_dbz  <= m_res[64];
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
        end
        m_rem <= m_rem - 1;
      end
    end
  end

  // Compare every output against the model each cycle.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("cyc_busy", {31'b0, Busy}, {31'b0, m_busy});
      chk("cyc_done", {31'b0, Done}, {31'b0, m_done});
      chk("cyc_dbz", {31'b0, DivByZero}, {31'b0, m_dbz});
      chk("cyc_hi", HI, m_hi);
      chk("cyc_lo", LO, m_lo);
    end
  end

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit noise,
                        input bit mv_start,
                        output int lat,
                        output logic [31:0] hi,
                        output logic [31:0] lo,
                        output logic dz);
    bit got;
    @(posedge clock); #2;
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    if (mv_start) begin
      MoveEn = 1'b1; MoveSel = 1'b0; MoveData = 32'hAAAA_5555;
    end
    @(posedge clock); #2;
    Start = 1'b0; MoveEn = 1'b0;
    @(posedge clock); #2;
    OperandA = $urandom; OperandB = $urandom; Op = 2'($urandom);
    lat = 1; got = 1'b0;
    hi = '0; lo = '0; dz = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (Done === 1'b1) begin
        got = 1'b1;
        break;
      end
      lat++;
      @(posedge clock); #2;
      if (noise) begin
        Start    = 1'($urandom_range(0, 1));
        MoveEn   = 1'($urandom_range(0, 1));
        MoveSel  = 1'($urandom_range(0, 1));
        MoveData = $urandom;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    hi = HI; lo = LO; dz = DivByZero;
    @(posedge clock); #2;
    Start = 1'b0; MoveEn = 1'b0;
  endtask

  task automatic do_move(input logic sel, input logic [31:0] d);
    @(posedge clock); #2;
    MoveEn = 1'b1; MoveSel = sel; MoveData = d;
    @(posedge clock); #2;
    MoveEn = 1'b0;
  endtask

  int          lat;
  logic [31:0] rh, rl;
  logic        rdz;
  logic [64:0] ex;
  int          dcnt;

  initial begin
    reset = 1'b1; Start = 1'b0; Op = 2'b00;
    OperandA = '0; OperandB = '0;
    MoveEn = 1'b0; MoveSel = 1'b0; MoveData = '0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
           lat, rh, rl, rdz);
    chk("multu_lat", lat, 32'd34);
    chk("multu_hi", rh, 32'hFFFF_FFFE);
    chk("multu_lo", rl, 32'h0000_0001);

    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, lat, rh, rl, rdz);
`ifdef MULTDIV_SIGNED_EN
    chk("mult_hi", rh, 32'hFFFF_FFFF);
`else
    chk("mult_hi", rh, 32'h0000_0004);
`endif
    chk("mult_lo", rl, 32'hFFFF_FFF1);

    run_op(2'b10, 32'd100, 32'd7, 0, 0, lat, rh, rl, rdz);
    chk("divu_lo", rl, 32'h0000_000E);
    chk("divu_hi", rh, 32'h0000_0002);

    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, rh, rl, rdz);
`ifdef MULTDIV_SIGNED_EN
    chk("div_lo", rl, 32'hFFFF_FFFD);
    chk("div_hi", rh, 32'hFFFF_FFFF);
`else
    chk("div_lo", rl, 32'h7FFF_FFFC);
    chk("div_hi", rh, 32'h0000_0001);
`endif

    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
           lat, rh, rl, rdz);
`ifdef MULTDIV_SIGNED_EN
    chk("divmin_lo", rl, 32'h8000_0000);
    chk("divmin_hi", rh, 32'h0000_0000);
`else
    chk("divmin_lo", rl, 32'h0000_0000);
    chk("divmin_hi", rh, 32'h8000_0000);
`endif

    run_op(2'b10, 32'd5, 32'd0, 0, 0, lat, rh, rl, rdz);
    chk("dbz_lat", lat, 32'd1);
    chk("dbz_flag", {31'b0, rdz}, 32'd1);
    chk("dbz_hi", rh, 32'h0000_0005);
    chk("dbz_lo", rl, 32'hFFFF_FFFF);

    do_move(1'b1, 32'h1234_5678);
    @(negedge clock);
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'hFFFF_FFFF);

    run_op(2'b00, 32'd3, 32'd4, 1, 1, lat, rh, rl, rdz);
    chk("mvstart_lo", rl, 32'd12);
    chk("mvstart_hi", rh, 32'd0);

    // Abort: second Start at edge 5 ignored, reset at edge 10.
    @(posedge clock); #2;
    Start = 1'b1; Op = 2'b00; OperandA = 32'd3; OperandB = 32'd4;
    for (int e = 0; e < 10; e++) begin
      @(posedge clock); #2;
      if (e == 0) Start = 1'b0;
      if (e == 4) begin
        Start = 1'b1; OperandA = 32'd7; OperandB = 32'd7;
      end
      if (e == 5) Start = 1'b0;
      if (e == 9) reset = 1'b1;
    end
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (Done === 1'b1) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          sel;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin
        ra = 32'($urandom_range(0, 200)) - 32'd100;
        rb = 32'($urandom_range(0, 20)) - 32'd10;
      end
      ex = ref_op(rop, ra, rb);
      run_op(rop, ra, rb, 1, 0, lat, rh, rl, rdz);
      chk("rnd_hi", rh, ex[63:32]);
      chk("rnd_lo", rl, ex[31:0]);
      chk("rnd_dbz", {31'b0, rdz}, {31'b0, ex[64]});
      if ($urandom_range(0, 2) == 0)
        do_move(1'($urandom_range(0, 1)), $urandom);
    end

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
